alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester round-robin arbiter and sequencer for the shared combinational `alu`. It accepts operand/opcode requests from two clients over valid/ready handshakes and grants one at a time. It drives the ALU from registered operands, captures the result and condition flags, and returns them on a per-requester response handshake. It sits between the issuing units and the single `alu` instance, which it owns exclusively.

## Interface
- `DATA_WIDTH`, 36, operand/result width; must match the `alu` instance.
- `ALU_OP_WIDTH`, 3, opcode width; encodings come from `alu_defs.vh`.
- `i_clk`  input  1  clock; all state changes on the rising edge.
- `i_rst`  input  1  reset, synchronous and active-high.
- `i_reqN_valid`  input  1  request N (N = 0, 1) valid.
- `o_reqN_ready`  output  1  request N accepted this cycle.
- `i_reqN_a`, `i_reqN_b`  input  DATA_WIDTH  operands for request N.
- `i_reqN_op`  input  ALU_OP_WIDTH  opcode for request N.
- `o_rspN_valid`  output  1  response N valid.
- `i_rspN_ready`  input  1  response N consumed.
- `o_rspN_result`  output  DATA_WIDTH  ALU result.
- `o_rspN_zero`, `o_rspN_negative`  output  1  condition flags.
- `o_alu_a`, `o_alu_b`  output  DATA_WIDTH  to ALU `i_a` / `i_b`.
- `o_alu_op`  output  ALU_OP_WIDTH  to ALU `i_ALUControlS`.
- `i_alu_result`  input  DATA_WIDTH  from ALU `o_ALU_Result`.
- `o_busy`  output  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If any `i_reqN_valid` is high, grant one requester.
  - Assert `o_reqN_ready` for the winner only. This is combinational from valid, state and priority pointer.
  - Latch a, b, op and owner ID; go to EXEC.
- **Arbitration**
  - 1-bit priority pointer; reset value favours requester 0.
  - If only one requester is valid, it wins.
  - If both are valid, the pointed-to requester wins.
  - After every grant, the pointer moves to the non-granted requester. Back-to-back contention therefore alternates 0, 1, 0, 1.
- **EXEC**
  - `o_alu_*` are driven from the latched registers.
  - At the end of the cycle, capture `i_alu_result` into the response register; go to RESP.
- **Flags**
  - The arbiter derives the flags itself from the captured result and does not use the ALU flag outputs.
  - Op = `ALU_SUBS`: zero = (result == 0); negative = result[DATA_WIDTH-1].
  - All other ops: both flags 0.
- **RESP**
  - `o_rspN_valid` is high for the owner only. Result and flags stay stable while valid is high.
  - On `i_rspN_ready`, go to IDLE.
  - No new grant is made in the handover cycle.
- **Protocol rules**
  - A requester holds valid and payload stable until ready.
  - Ready is never asserted outside IDLE.
- **Arithmetic:** all operations wrap modulo 2^DATA_WIDTH; the arbiter adds no extension bits.

## Timing
- **Reset values:** state IDLE, pointer = requester 0, all `o_reqN_ready` 0, all `o_rspN_valid` 0, results and flags 0, `o_alu_a`/`o_alu_b`/`o_alu_op` 0, `o_busy` 0.
- **Latency:** grant at cycle T (IDLE), EXEC at T+1, response valid at T+2. Minimum issue interval is 3 cycles when the response is accepted immediately.
- **Backpressure:** `i_rspN_ready` low holds RESP indefinitely. The other requester waits and its valid is not acknowledged.
- **Reset mid-operation:** the transaction is abandoned with no response. The requester must re-issue.
- **Both valid at reset release:** requester 0 is granted first.

## Configuration
- Macro: `ALU_ARB_OPCHECK_EN`.
- **Defined**
  - Adds `o_rspN_err` (output, 1, reset 0).
  - An opcode outside {ADD, SUB, SUBS, AND, OR} is not forwarded: `o_alu_op` keeps its previous value.
  - Response result = 0, flags 0, err = 1. Err is valid alongside `o_rspN_valid`.
  - Latency is unchanged.
- **Undefined**
  - No err port.
  - Every opcode is forwarded unchanged and the ALU output is captured as-is.

## Test plan
- **Single request:** reset, then req0 ADD a=5, b=7 → ready0 for one cycle; `o_alu_a`=5, `o_alu_b`=7 at T+1; rsp0 valid at T+2 with result 12, zero 0, negative 0.
- **SUBS flags:** req1 SUBS a=3, b=3 → result 0, zero 1, negative 0. SUBS a=2, b=5 → result 2^36−3, zero 0, negative 1.
- **Contention:** both valid continuously, each acking its response immediately → grants 0, 1, 0, 1 with one grant every 3 cycles; each response goes only to its owner.
- **Backpressure:** hold `i_rsp0_ready` low for 10 cycles with req1 valid → rsp0 stays valid and stable, ready1 stays 0, `o_busy` stays 1. Release → IDLE, then req1 is granted the next cycle.
- **Reset mid-EXEC:** pulse `i_rst` during EXEC → next cycle all outputs are at reset values and no `o_rspN_valid` appears.
- **With `ALU_ARB_OPCHECK_EN`:** issue an undefined opcode → response result 0, err 1, `o_alu_op` unchanged from the prior op.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester round-robin arbiter and sequencer for the shared alu.
// Requests are granted in IDLE, operands are driven to the alu from registers in EXEC,
// and the captured result plus derived flags are returned in RESP.
// Optional build macro: ALU_ARB_OPCHECK_EN rejects opcodes outside {ADD, SUB, SUBS, AND, OR}
// and adds the o_rsp0_err / o_rsp1_err outputs.
module alu_arbiter #(
   parameter int DATA_WIDTH   = 36,
   parameter int ALU_OP_WIDTH = 3
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_req0_valid,
   output logic                    o_req0_ready,
   input  logic [DATA_WIDTH-1:0]   i_req0_a,
   input  logic [DATA_WIDTH-1:0]   i_req0_b,
   input  logic [ALU_OP_WIDTH-1:0] i_req0_op,
   input  logic                    i_req1_valid,
   output logic                    o_req1_ready,
   input  logic [DATA_WIDTH-1:0]   i_req1_a,
   input  logic [DATA_WIDTH-1:0]   i_req1_b,
   input  logic [ALU_OP_WIDTH-1:0] i_req1_op,
   output logic                    o_rsp0_valid,
   input  logic                    i_rsp0_ready,
   output logic [DATA_WIDTH-1:0]   o_rsp0_result,
   output logic                    o_rsp0_zero,
   output logic                    o_rsp0_negative,
   output logic                    o_rsp1_valid,
   input  logic                    i_rsp1_ready,
   output logic [DATA_WIDTH-1:0]   o_rsp1_result,
   output logic                    o_rsp1_zero,
   output logic                    o_rsp1_negative,
   output logic [DATA_WIDTH-1:0]   o_alu_a,
   output logic [DATA_WIDTH-1:0]   o_alu_b,
   output logic [ALU_OP_WIDTH-1:0] o_alu_op,
   input  logic [DATA_WIDTH-1:0]   i_alu_result,
`ifdef ALU_ARB_OPCHECK_EN
   output logic                    o_rsp0_err,
   output logic                    o_rsp1_err,
`endif
   output logic                    o_busy
);

   // Opcode encodings shared with alu_defs.vh.
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SUBS = ALU_OP_WIDTH'(4);
`ifdef ALU_ARB_OPCHECK_EN
   localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD  = ALU_OP_WIDTH'(0);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB  = ALU_OP_WIDTH'(1);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_AND  = ALU_OP_WIDTH'(2);
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OR   = ALU_OP_WIDTH'(3);
`endif

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t                  state_reg, state_next;
   logic                    ptr_reg;      // requester favoured when both are valid
   logic                    owner_reg;    // requester that owns the current transaction
   logic [DATA_WIDTH-1:0]   a_reg, b_reg, result_reg;
   logic [ALU_OP_WIDTH-1:0] op_reg;
   logic                    subs_reg, zero_reg, neg_reg;
   logic                    grant, win, rsp_ready_sel;
   logic [1:0]              req_valid, req_ready, rsp_valid, rsp_ready;
   logic [ALU_OP_WIDTH-1:0] win_op;
`ifdef ALU_ARB_OPCHECK_EN
   logic                    bad_reg, err_reg, win_op_ok;
`endif

   assign req_valid = {i_req1_valid, i_req0_valid};
   assign rsp_ready = {i_rsp1_ready, i_rsp0_ready};

   // Winner: a lone valid requester, otherwise the one the pointer favours.
   assign win           = req_valid[1] & (~req_valid[0] | ptr_reg);
   assign win_op        = win ? i_req1_op : i_req0_op;
   assign rsp_ready_sel = rsp_ready[owner_reg];

`ifdef ALU_ARB_OPCHECK_EN
   assign win_op_ok = (win_op == ALU_ADD) || (win_op == ALU_SUB) || (win_op == ALU_SUBS) ||
                      (win_op == ALU_AND) || (win_op == ALU_OR);
`endif

   // Per-requester handshake outputs: only the winner sees ready, only the owner sees valid.
   for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign req_ready[gi] = grant & (win == 1'(gi));
      assign rsp_valid[gi] = (state_reg == RESP) & (owner_reg == 1'(gi));
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   // Next-state and grant decode; ready is held low while reset is asserted.
   always_comb begin
      state_next = state_reg;
      grant      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!i_rst && (|req_valid)) begin
               grant      = 1'b1;
               state_next = EXEC;
            end
         end
         EXEC:    state_next = RESP;
         RESP:    if (rsp_ready_sel) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: latch the granted request, then capture the alu result at the end of EXEC.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr_reg    <= 1'b0;
         owner_reg  <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         op_reg     <= '0;
         subs_reg   <= 1'b0;
         result_reg <= '0;
         zero_reg   <= 1'b0;
         neg_reg    <= 1'b0;
`ifdef ALU_ARB_OPCHECK_EN
         bad_reg    <= 1'b0;
         err_reg    <= 1'b0;
`endif
      end else begin
         if (grant) begin
            ptr_reg   <= ~win;
            owner_reg <= win;
            a_reg     <= win ? i_req1_a : i_req0_a;
            b_reg     <= win ? i_req1_b : i_req0_b;
            subs_reg  <= (win_op == ALU_SUBS);
`ifdef ALU_ARB_OPCHECK_EN
            // An unsupported opcode never reaches the alu; the previous op stays on the bus.
            if (win_op_ok) op_reg <= win_op;
            bad_reg <= ~win_op_ok;
`else
            op_reg    <= win_op;
`endif
         end
         if (state_reg == EXEC) begin
`ifdef ALU_ARB_OPCHECK_EN
            if (bad_reg) begin
               result_reg <= '0;
               zero_reg   <= 1'b0;
               neg_reg    <= 1'b0;
               err_reg    <= 1'b1;
            end else begin
               result_reg <= i_alu_result;
               zero_reg   <= subs_reg & (i_alu_result == '0);
               neg_reg    <= subs_reg & i_alu_result[DATA_WIDTH-1];
               err_reg    <= 1'b0;
            end
`else
            result_reg <= i_alu_result;
            zero_reg   <= subs_reg & (i_alu_result == '0);
            neg_reg    <= subs_reg & i_alu_result[DATA_WIDTH-1];
`endif
         end
      end
   end

   assign o_req0_ready    = req_ready[0];
   assign o_req1_ready    = req_ready[1];
   assign o_rsp0_valid    = rsp_valid[0];
   assign o_rsp1_valid    = rsp_valid[1];
   assign o_rsp0_result   = result_reg;
   assign o_rsp1_result   = result_reg;
   assign o_rsp0_zero     = zero_reg;
   assign o_rsp1_zero     = zero_reg;
   assign o_rsp0_negative = neg_reg;
   assign o_rsp1_negative = neg_reg;
   assign o_alu_a         = a_reg;
   assign o_alu_b         = b_reg;
   assign o_alu_op        = op_reg;
   assign o_busy          = (state_reg != IDLE);
`ifdef ALU_ARB_OPCHECK_EN
   assign o_rsp0_err      = err_reg;
   assign o_rsp1_err      = err_reg;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a behavioural alu.
// Honours ALU_ARB_OPCHECK_EN when the design is built with it.
module tb_alu_arbiter;

   localparam int DW = 36;
   localparam int OW = 3;
   localparam logic [OW-1:0] OP_ADD  = 3'd0;
   localparam logic [OW-1:0] OP_SUB  = 3'd1;
   localparam logic [OW-1:0] OP_AND  = 3'd2;
   localparam logic [OW-1:0] OP_OR   = 3'd3;
   localparam logic [OW-1:0] OP_SUBS = 3'd4;
   localparam logic [OW-1:0] OP_BAD  = 3'd7;
   localparam logic [DW-1:0] ALU_JUNK = 36'h0_DEAD_BEEF;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [1:0]    req_valid, rsp_ready;
   logic [DW-1:0] req_a [2];
   logic [DW-1:0] req_b [2];
   logic [OW-1:0] req_op [2];
   logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
   logic [DW-1:0] rsp0_result, rsp1_result;
   logic          rsp0_zero, rsp1_zero, rsp0_neg, rsp1_neg;
   logic [DW-1:0] alu_a, alu_b, alu_result;
   logic [OW-1:0] alu_op;
   logic          busy;
`ifdef ALU_ARB_OPCHECK_EN
   logic          rsp0_err, rsp1_err;
`endif

   logic [1:0]    req_ready, rsp_valid;
   assign req_ready = {req1_ready, req0_ready};
   assign rsp_valid = {rsp1_valid, rsp0_valid};

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model of the shared alu.
   always_comb begin
      case (alu_op)
         OP_ADD:          alu_result = alu_a + alu_b;
         OP_SUB, OP_SUBS: alu_result = alu_a - alu_b;
         OP_AND:          alu_result = alu_a & alu_b;
         OP_OR:           alu_result = alu_a | alu_b;
         default:         alu_result = ALU_JUNK;
      endcase
   end

   alu_arbiter #(.DATA_WIDTH(DW), .ALU_OP_WIDTH(OW)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req0_valid(req_valid[0]), .o_req0_ready(req0_ready),
      .i_req0_a(req_a[0]), .i_req0_b(req_b[0]), .i_req0_op(req_op[0]),
      .i_req1_valid(req_valid[1]), .o_req1_ready(req1_ready),
      .i_req1_a(req_a[1]), .i_req1_b(req_b[1]), .i_req1_op(req_op[1]),
      .o_rsp0_valid(rsp0_valid), .i_rsp0_ready(rsp_ready[0]),
      .o_rsp0_result(rsp0_result), .o_rsp0_zero(rsp0_zero), .o_rsp0_negative(rsp0_neg),
      .o_rsp1_valid(rsp1_valid), .i_rsp1_ready(rsp_ready[1]),
      .o_rsp1_result(rsp1_result), .o_rsp1_zero(rsp1_zero), .o_rsp1_negative(rsp1_neg),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_op(alu_op), .i_alu_result(alu_result),
`ifdef ALU_ARB_OPCHECK_EN
      .o_rsp0_err(rsp0_err), .o_rsp1_err(rsp1_err),
`endif
      .o_busy(busy)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One complete transaction on requester n with the response accepted immediately.
   task automatic txn(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [OW-1:0] op, input logic [OW-1:0] exp_alu_op,
                      input logic [DW-1:0] exp_res, input logic exp_z, input logic exp_n,
                      input logic exp_err);
      logic [1:0]    onehot;
      logic [DW-1:0] res;
      logic          z, ng;
      onehot       = (n == 0) ? 2'b01 : 2'b10;
      req_a[n]     = a;
      req_b[n]     = b;
      req_op[n]    = op;
      req_valid[n] = 1'b1;
      rsp_ready[n] = 1'b1;
      #1;
      check("txn_grant", req_ready, onehot);
      check("txn_idle_busy", busy, 0);
      tick();
      req_valid[n] = 1'b0;
      #1;
      check("exec_alu_a", alu_a, a);
      check("exec_alu_b", alu_b, b);
      check("exec_alu_op", alu_op, exp_alu_op);
      check("exec_busy", busy, 1);
      check("exec_no_ready", req_ready, 0);
      check("exec_no_rsp", rsp_valid, 0);
      tick();
      res = (n == 0) ? rsp0_result : rsp1_result;
      z   = (n == 0) ? rsp0_zero : rsp1_zero;
      ng  = (n == 0) ? rsp0_neg : rsp1_neg;
      check("rsp_valid", rsp_valid, onehot);
      check("rsp_result", res, exp_res);
      check("rsp_zero", z, exp_z);
      check("rsp_negative", ng, exp_n);
`ifdef ALU_ARB_OPCHECK_EN
      check("rsp_err", (n == 0) ? rsp0_err : rsp1_err, exp_err);
`else
      if (exp_err) check("rsp_err_unexpected", 1'b0, 1'b1);
`endif
      tick();
      rsp_ready[n] = 1'b0;
      #1;
      check("post_rsp_valid", rsp_valid, 0);
      check("post_rsp_busy", busy, 0);
      $display("txn req%0d op=%0d a=%0h b=%0h -> result=%0h zero=%0b neg=%0b",
               n, op, a, b, res, z, ng);
   endtask

   initial begin
      logic [1:0] exp_win;
      rst       = 1'b1;
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      for (int i = 0; i < 2; i++) begin
         req_a[i] = '0; req_b[i] = '0; req_op[i] = '0;
      end
      tick();
      tick();
      rst = 1'b0;
      #1;
      // Reset values
      check("rst_ready", req_ready, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_result", rsp0_result, 0);
      check("rst_zero", rsp0_zero, 0);
      check("rst_neg", rsp0_neg, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_alu_op", alu_op, 0);
      check("rst_busy", busy, 0);
      $display("reset released, outputs idle");

      // Single requests and flag derivation
      txn(0, 36'd5, 36'd7, OP_ADD, OP_ADD, 36'd12, 1'b0, 1'b0, 1'b0);
      txn(1, 36'd3, 36'd3, OP_SUBS, OP_SUBS, 36'd0, 1'b1, 1'b0, 1'b0);
      txn(1, 36'd2, 36'd5, OP_SUBS, OP_SUBS, 36'hF_FFFF_FFFD, 1'b0, 1'b1, 1'b0);
      txn(0, 36'd2, 36'd5, OP_SUB, OP_SUB, 36'hF_FFFF_FFFD, 1'b0, 1'b0, 1'b0);
      txn(0, 36'd3, 36'd3, OP_SUB, OP_SUB, 36'd0, 1'b0, 1'b0, 1'b0);
      txn(1, 36'hF_0000_00FF, 36'h0_FFFF_FF0F, OP_AND, OP_AND, 36'h0_0000_000F, 1'b0, 1'b0, 1'b0);
      txn(0, 36'h8_0000_0000, 36'd1, OP_OR, OP_OR, 36'h8_0000_0001, 1'b0, 1'b0, 1'b0);

      // Unsupported opcode, preceded by a good ADD so the forwarded op is known
      txn(0, 36'd5, 36'd7, OP_ADD, OP_ADD, 36'd12, 1'b0, 1'b0, 1'b0);
`ifdef ALU_ARB_OPCHECK_EN
      txn(0, 36'd9, 36'd4, OP_BAD, OP_ADD, 36'd0, 1'b0, 1'b0, 1'b1);
`else
      txn(0, 36'd9, 36'd4, OP_BAD, OP_BAD, ALU_JUNK, 1'b0, 1'b0, 1'b0);
`endif

      // Contention from reset release: grants alternate 0,1,0,1 every 3 cycles
      rst       = 1'b1;
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      req_a[0] = 36'd1; req_b[0] = 36'd1; req_op[0] = OP_ADD;
      req_a[1] = 36'd8; req_b[1] = 36'd1; req_op[1] = OP_OR;
      tick();
      check("rst_hold_ready", req_ready, 0);
      tick();
      rst = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         exp_win = (k % 2 == 0) ? 2'b01 : 2'b10;
         check("cont_grant", req_ready, exp_win);
         tick();
         check("cont_exec_ready", req_ready, 0);
         check("cont_exec_a", alu_a, (k % 2 == 0) ? 36'd1 : 36'd8);
         tick();
         check("cont_rsp_owner", rsp_valid, exp_win);
         check("cont_rsp_ready", req_ready, 0);
         check("cont_rsp_result", (k % 2 == 0) ? rsp0_result : rsp1_result,
               (k % 2 == 0) ? 36'd2 : 36'd9);
         $display("contention round %0d granted req%0d", k, (k % 2 == 0) ? 0 : 1);
         if (k == 3) req_valid = 2'b00;
         tick();
      end
      check("cont_end_idle", busy, 0);
      rsp_ready = 2'b00;

      // Backpressure: rsp0 held for 10 cycles while req1 waits
      req_valid[0] = 1'b1;
      req_a[0] = 36'h123; req_b[0] = 36'h456; req_op[0] = OP_ADD;
      #1;
      check("bp_grant0", req_ready, 2'b01);
      tick();
      req_valid[0] = 1'b0;
      req_valid[1] = 1'b1;
      req_a[1] = 36'h10; req_b[1] = 36'd3; req_op[1] = OP_SUB;
      #1;
      check("bp_exec_ready", req_ready, 0);
      tick();
      for (int k = 0; k < 10; k++) begin
         check("bp_rsp_valid", rsp_valid, 2'b01);
         check("bp_rsp_result", rsp0_result, 36'h579);
         check("bp_ready1", req_ready, 0);
         check("bp_busy", busy, 1);
         tick();
      end
      rsp_ready[0] = 1'b1;
      tick();
      rsp_ready[0] = 1'b0;
      #1;
      check("bp_release_grant1", req_ready, 2'b10);
      check("bp_release_rsp", rsp_valid, 0);
      tick();
      req_valid[1] = 1'b0;
      rsp_ready[1] = 1'b1;
      tick();
      check("bp_rsp1_valid", rsp_valid, 2'b10);
      check("bp_rsp1_result", rsp1_result, 36'h00D);
      tick();
      rsp_ready[1] = 1'b0;
      $display("backpressure: rsp0=579 held 10 cycles, then req1 result=00d");

      // Reset during EXEC abandons the transaction
      req_valid[0] = 1'b1;
      req_a[0] = 36'd5; req_b[0] = 36'd7; req_op[0] = OP_OR;
      rsp_ready[0] = 1'b1;
      #1;
      check("rx_grant", req_ready, 2'b01);
      tick();
      req_valid[0] = 1'b0;
      #1;
      check("rx_exec_busy", busy, 1);
      check("rx_exec_op", alu_op, OP_OR);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("rx_alu_a", alu_a, 0);
      check("rx_alu_b", alu_b, 0);
      check("rx_alu_op", alu_op, 0);
      check("rx_result", rsp0_result, 0);
      check("rx_rsp_valid", rsp_valid, 0);
      check("rx_busy", busy, 0);
      tick();
      check("rx_no_rsp_1", rsp_valid, 0);
      tick();
      check("rx_no_rsp_2", rsp_valid, 0);
      rsp_ready = 2'b00;
      $display("reset during EXEC: transaction dropped");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
